frame_rcv_fsm: RTL

Receive-side frame deframer, the counterpart of the transmit frame processor. Accepts 16-bit 8b10b-decoded words from the link, locks on SOP/preamble/SOF, strips framing and the 32-bit CRC trailer, and delivers payload words with start/end markers. Checks the CRC and reports frame status and error counts to slow control.

---
 rtl/frame_pkg.sv | 62 ++++++
 rtl/crc32_d16.sv | 25 ++
 rtl/frame_rcv_fsm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the receive deframer.
// Word classes, state encoding, CRC constants and helpers.
package frame_pkg;

  localparam logic [15:0] W_SOP  = 16'hFB55;
  localparam logic [1:0]  K_SOP  = 2'b10;
  localparam logic [15:0] W_PRE  = 16'h5555;
  localparam logic [1:0]  K_PRE  = 2'b00;
  localparam logic [15:0] W_SOF  = 16'hD555;
  localparam logic [1:0]  K_SOF  = 2'b00;
  localparam logic [15:0] W_EOP  = 16'hFDF7;
  localparam logic [1:0]  K_EOP  = 2'b11;
  localparam logic [15:0] W_IDLE = 16'h50BC;
  localparam logic [1:0]  K_IDLE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE1 = 3'd1,
    ST_PRE2 = 3'd2,
    ST_PRE3 = 3'd3,
    ST_SOF  = 3'd4,
    ST_DATA = 3'd5,
    ST_DROP = 3'd6
  } state_e;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Control word that is triplicated when hardening is enabled.
  typedef struct packed {
    state_e     st;
    logic [1:0] hbn;
    logic       vld;
    logic       sof;
    logic       eof;
    logic       ok;
    logic       err;
    logic       ferr;
  } ctl_t;

  function automatic logic [31:0] crc32_upd16(
    input logic [31:0] c,
    input logic [15:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ CRC_POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  function automatic ctl_t vote3(
    input ctl_t a,
    input ctl_t b,
    input ctl_t c
  );
    return ctl_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/crc32_d16.sv
// CRC-32 accumulator, 16 bits per cycle, MSB first.
// nxt_o is the combinational update of the held value with d_i.
module crc32_d16
  import frame_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] d_i,
  output logic [31:0] nxt_o
);

  logic [31:0] crc_q;

  assign nxt_o = crc32_upd16(crc_q, d_i);

  // Accumulate one word per enabled cycle, restart on clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)     crc_q <= CRC_INIT;
    else if (clr_i)  crc_q <= CRC_INIT;
    else if (en_i)   crc_q <= nxt_o;
  end

endmodule

// File: rtl/frame_rcv_fsm.sv
// Receive deframer: preamble lock, holdback, CRC check, counters.
// Define FRAME_RCV_TMR_EN for triplicated control registers.
module frame_rcv_fsm
  import frame_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] RX_DATA,
  input  logic [1:0]  RX_K,
  input  logic        RX_VALID,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  output logic        DOUT_SOF,
  output logic        DOUT_EOF,
  output logic        CRC_OK,
  output logic        CRC_ERR,
  output logic        FRM_ERR,
  output logic [2:0]  FRM_STATE,
  output logic [15:0] FRM_CNT,
  output logic [15:0] ERR_CNT
);

  localparam logic [11:0] WMAX = 12'(MAX_WORDS + 2);

`ifdef FRAME_RCV_TMR_EN
  localparam int NCP = 3;
  (* syn_preserve = 1 *) ctl_t ctl_q [NCP];
  (* syn_keep = 1 *)     ctl_t ctl_v;
  assign ctl_v = vote3(ctl_q[0], ctl_q[1], ctl_q[2]);
`else
  localparam int NCP = 1;
  ctl_t ctl_q [NCP];
  ctl_t ctl_v;
  assign ctl_v = ctl_q[0];
`endif

  ctl_t        ctl_d;
  logic [15:0] hb_q [3];
  logic [15:0] hb_d [3];
  logic [15:0] dout_q, dout_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic        first_q, first_d;
  logic [15:0] frm_q, frm_d;
  logic [15:0] errc_q, errc_d;

  logic        crc_clr, crc_en;
  logic [31:0] crc_nxt;

  logic is_sop, is_pre, is_sof, is_eop, is_idle, is_dat;

  assign is_sop  = (RX_DATA == W_SOP)  && (RX_K == K_SOP);
  assign is_pre  = (RX_DATA == W_PRE)  && (RX_K == K_PRE);
  assign is_sof  = (RX_DATA == W_SOF)  && (RX_K == K_SOF);
  assign is_eop  = (RX_DATA == W_EOP)  && (RX_K == K_EOP);
  assign is_idle = (RX_DATA == W_IDLE) && (RX_K == K_IDLE);
  assign is_dat  = (RX_K == 2'b00);

  crc32_d16 u_crc (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .d_i    (hb_q[0]),
    .nxt_o  (crc_nxt)
  );

  // Next-state, holdback and output pulse computation.
  always_comb begin
    ctl_d      = ctl_v;
    ctl_d.vld  = 1'b0;
    ctl_d.sof  = 1'b0;
    ctl_d.eof  = 1'b0;
    ctl_d.ok   = 1'b0;
    ctl_d.err  = 1'b0;
    ctl_d.ferr = 1'b0;
    hb_d       = hb_q;
    dout_d     = dout_q;
    wcnt_d     = wcnt_q;
    first_d    = first_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    if (RX_VALID) begin
      unique case (ctl_v.st)
        ST_IDLE: begin
          if (is_sop) ctl_d.st = ST_PRE1;
        end
        ST_PRE1, ST_PRE2, ST_PRE3: begin
          if (is_pre) begin
            ctl_d.st = state_e'(ctl_v.st + 3'd1);
          end else begin
            ctl_d.st   = ST_DROP;
            ctl_d.ferr = 1'b1;
          end
        end
        ST_SOF: begin
          if (is_sof) begin
            ctl_d.st  = ST_DATA;
            ctl_d.hbn = 2'd0;
            wcnt_d    = '0;
            first_d   = 1'b1;
            crc_clr   = 1'b1;
          end else begin
            ctl_d.st   = ST_DROP;
            ctl_d.ferr = 1'b1;
          end
        end
        ST_DATA: begin
          if (is_dat) begin
            if (ctl_v.hbn == 2'd3) begin
              ctl_d.vld = 1'b1;
              ctl_d.sof = first_q;
              first_d   = 1'b0;
              dout_d    = hb_q[0];
              crc_en    = 1'b1;
              hb_d[0]   = hb_q[1];
              hb_d[1]   = hb_q[2];
              hb_d[2]   = RX_DATA;
            end else begin
              hb_d[ctl_v.hbn] = RX_DATA;
              ctl_d.hbn       = ctl_v.hbn + 2'd1;
            end
            if (wcnt_q == WMAX) begin
              ctl_d.st   = ST_DROP;
              ctl_d.ferr = 1'b1;
              ctl_d.hbn  = 2'd0;
            end else begin
              wcnt_d = wcnt_q + 12'd1;
            end
          end else if (is_eop) begin
            ctl_d.st  = ST_IDLE;
            ctl_d.hbn = 2'd0;
            if (ctl_v.hbn != 2'd3) begin
              ctl_d.ferr = 1'b1;
            end else begin
              ctl_d.vld = 1'b1;
              ctl_d.eof = 1'b1;
              ctl_d.sof = first_q;
              first_d   = 1'b0;
              dout_d    = hb_q[0];
              crc_en    = 1'b1;
              ctl_d.ok  = (crc_nxt == {hb_q[1], hb_q[2]});
              ctl_d.err = (crc_nxt != {hb_q[1], hb_q[2]});
            end
          end else begin
            ctl_d.st   = ST_DROP;
            ctl_d.ferr = 1'b1;
            ctl_d.hbn  = 2'd0;
          end
        end
        ST_DROP: begin
          if (is_eop || is_idle) ctl_d.st = ST_IDLE;
          else if (is_sop)       ctl_d.st = ST_PRE1;
        end
        default: begin
          ctl_d.st  = ST_IDLE;
          ctl_d.hbn = 2'd0;
        end
      endcase
    end
    frm_d  = frm_q;
    errc_d = errc_q;
    if (ctl_d.ok && frm_q != 16'hFFFF)
      frm_d = frm_q + 16'd1;
    if ((ctl_d.err || ctl_d.ferr) && errc_q != 16'hFFFF)
      errc_d = errc_q + 16'd1;
  end

  // Register control copies, holdback, output data and counters.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NCP; i++) ctl_q[i] <= '0;
      hb_q    <= '{default: '0};
      dout_q  <= '0;
      wcnt_q  <= '0;
      first_q <= 1'b0;
      frm_q   <= '0;
      errc_q  <= '0;
    end else begin
      for (int i = 0; i < NCP; i++) ctl_q[i] <= ctl_d;
      hb_q    <= hb_d;
      dout_q  <= dout_d;
      wcnt_q  <= wcnt_d;
      first_q <= first_d;
      frm_q   <= frm_d;
      errc_q  <= errc_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = ctl_v.vld;
  assign DOUT_SOF   = ctl_v.sof;
  assign DOUT_EOF   = ctl_v.eof;
  assign CRC_OK     = ctl_v.ok;
  assign CRC_ERR    = ctl_v.err;
  assign FRM_ERR    = ctl_v.ferr;
  assign FRM_STATE  = ctl_v.st;
  assign FRM_CNT    = frm_q;
  assign ERR_CNT    = errc_q;

endmodule
